// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - shared op codes and FSM state encoding for alu_mdu
package alu_mdu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// rtl/alu_mdu_iter.sv - bit-serial unsigned multiply / restoring divide datapath
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse; operands and mode are taken on this edge
//   mul            1 = multiply (src_a * src_b), 0 = divide (src_a / src_b)
//   src_a, src_b   operands
//   done           one-cycle pulse; hi/lo hold the final result while it is high
//   hi, lo         multiply: product high/low; divide: remainder/quotient
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mul,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] dreg;
    logic             mode;
    logic             running;
    logic [CW-1:0]    count;

    // The start edge already performs the first step on the raw operands,
    // so the whole operation completes in exactly WIDTH edges.
    logic [WIDTH-1:0] cur_hi, cur_lo, cur_d;
    logic             cur_mul;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    always_comb begin
        cur_hi    = start ? '0 : hi;
        cur_lo    = start ? (mul ? src_b : src_a) : lo;
        cur_d     = start ? (mul ? src_a : src_b) : dreg;
        cur_mul   = start ? mul : mode;
        mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_d} : '0);
        div_shift = {cur_hi, cur_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, cur_d};
        if (cur_mul) begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], cur_lo[WIDTH-1:1]};
        end else begin
            // Restoring step: keep the partial remainder when the trial subtract borrows.
            nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            dreg    <= '0;
            mode    <= 1'b0;
            running <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || running) begin
                hi   <= nxt_hi;
                lo   <= nxt_lo;
                dreg <= cur_d;
                mode <= cur_mul;
            end
            if (start) begin
                running <= 1'b1;
                count   <= CW'(1);
            end else if (running) begin
                count <= count + 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - single-cycle ALU with iterative unsigned multiply/divide
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    request handshake (ready only in IDLE)
//   op, src_a, src_b      operation code and operands
//   out_valid, out_ready  result handshake (valid only in DONE)
//   result_lo, result_hi  primary result / product low / quotient; product high / remainder
//   zero, overflow        result_lo == 0; signed overflow for ADD/SUB
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);

    localparam int SW = $clog2(WIDTH);

    state_t state, state_next;

    logic [WIDTH-1:0] sum, diff, alu_lo, alu_hi;
    logic [SW-1:0]    shamt;
    logic             alu_ovf, use_iter, start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Divide by zero bypasses the iterative path and completes in one cycle.
    assign use_iter = (op == OP_MULU) || ((op == OP_DIVU) && (src_b != '0));
    assign start    = in_ready && in_valid && use_iter;

    assign sum   = src_a + src_b;
    assign diff  = src_a + ~src_b + 1'b1;
    assign shamt = src_b[SW-1:0];

    always_comb begin
        alu_lo  = '0;
        alu_hi  = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_lo  = sum;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo  = diff;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  alu_lo = src_a & src_b;
            OP_OR:   alu_lo = src_a | src_b;
            OP_XOR:  alu_lo = src_a ^ src_b;
            OP_NOR:  alu_lo = ~(src_a | src_b);
            OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SLL:  alu_lo = src_a << shamt;
            OP_SRL:  alu_lo = src_a >> shamt;
            OP_SRA:  alu_lo = WIDTH'($signed(src_a) >>> shamt);
            OP_DIVU: begin
                alu_lo = '1;
                alu_hi = src_a;
            end
            default: ;
        endcase
    end

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mul   (op == OP_MULU),
        .src_a (src_a),
        .src_b (src_b),
        .done  (iter_done),
        .hi    (iter_hi),
        .lo    (iter_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = use_iter ? BUSY : DONE;
            BUSY:    if (iter_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && !use_iter) begin
                    result_lo <= alu_lo;
                    result_hi <= alu_hi;
                    zero      <= (alu_lo == '0);
                    overflow  <= alu_ovf;
                end
                BUSY: if (iter_done) begin
                    result_lo <= iter_lo;
                    result_hi <= iter_hi;
                    zero      <= (iter_lo == '0);
                    overflow  <= 1'b0;
                end
                DONE: if (out_ready) begin
                    // Flags are only meaningful alongside out_valid.
                    zero     <= 1'b0;
                    overflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
